// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the RAM loader.
// Define UART_RX_FIFO_OVF_EN to build the sticky overflow flag (ovf_o / ovf_clr_i).
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_vld_i,
  output logic                       in_rdy_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  input  logic                       ovf_clr_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;

  logic [AW-1:0] wrIdx;
  logic [AW-1:0] rdIdx;
  logic          empty;
  logic          full;
  logic          wrEn;
  logic          rdEn;

  assign wrIdx = wrPtr_q[AW-1:0];
  assign rdIdx = rdPtr_q[AW-1:0];

  // The extra wrap bit tells full from empty when the index bits coincide.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrIdx == rdIdx) && (wrPtr_q[AW] != rdPtr_q[AW]);

  assign in_rdy_o  = !full && !rst_i;
  assign out_vld_o = !empty;
  assign wrEn      = in_vld_i && in_rdy_o;
  assign rdEn      = out_vld_o && out_rdy_i;

  assign out_data_o = empty ? '0 : mem[rdIdx];
  assign level_o    = wrPtr_q - rdPtr_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (wrEn) wrPtr_d = wrPtr_q + PW'(1);
    if (rdEn) rdPtr_d = rdPtr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is not reset; wrEn is already blocked while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (wrEn) mem[wrIdx] <= in_data_i;
  end

`ifdef UART_RX_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  logic ovfEvent;

  assign ovfEvent = in_vld_i && !in_rdy_o && !rst_i;

  // Set has priority over clear so a byte lost during a clear is never hidden.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (ovfEvent)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unusedOvfClr;
  assign unusedOvfClr = ovf_clr_i;
  assign ovf_o        = 1'b0;
`endif

endmodule
